// File: rtl/eth_stats_pkg.sv
// Shared event map and defaults for the MAC statistics counter block.
package eth_stats_pkg;

  localparam int unsigned DEFAULT_NUM_EVENTS = 8;

  // Per-port event bit positions within a port's evt_pulse slice
  localparam int unsigned EVT_TX_UNDERFLOW = 0;
  localparam int unsigned EVT_TX_FIFO_OVF  = 1;
  localparam int unsigned EVT_TX_FIFO_BAD  = 2;
  localparam int unsigned EVT_TX_FIFO_GOOD = 3;
  localparam int unsigned EVT_RX_BAD_FRAME = 4;
  localparam int unsigned EVT_RX_BAD_FCS   = 5;
  localparam int unsigned EVT_RX_FIFO_OVF  = 6;
  localparam int unsigned EVT_RX_FIFO_GOOD = 7;

endpackage

// File: rtl/eth_stats_cnt.sv
// Single event counter with clear, saturate-or-wrap, and a sticky limit flag.
module eth_stats_cnt #(
  parameter int unsigned CNT_WIDTH = 32,
  parameter bit          SATURATE  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] value,
  output logic                 sat,
  output logic                 sat_next_c
);

  logic [CNT_WIDTH-1:0] value_next_c;

  // Next value: clear wins but still keeps a same-cycle event
  always_comb begin
    value_next_c = value;
    sat_next_c   = sat;
    if (clr) begin
      value_next_c = CNT_WIDTH'(inc);
      sat_next_c   = 1'b0;
    end else if (inc) begin
      if (&value) begin
        sat_next_c   = 1'b1;
        value_next_c = SATURATE ? value : '0;
      end else begin
        value_next_c = value + CNT_WIDTH'(1);
      end
    end
  end

  // Counter and flag state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
      sat   <= 1'b0;
    end else begin
      value <= value_next_c;
      sat   <= sat_next_c;
    end
  end

endmodule

// File: rtl/eth_mac_stats_counters.sv
// Per-port, per-event MAC statistics counters with a registered read port.
module eth_mac_stats_counters
  import eth_stats_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned NUM_EVENTS = DEFAULT_NUM_EVENTS,
  parameter int unsigned CNT_WIDTH  = 32,
  parameter bit          SATURATE   = 1'b1,
  parameter int unsigned PORT_SEL_W = 4,
  parameter int unsigned EVT_SEL_W  = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_PORTS*NUM_EVENTS-1:0] evt_pulse,
  input  logic                            clear_all,
  input  logic                            rd_req,
  input  logic [PORT_SEL_W-1:0]           rd_port,
  input  logic [EVT_SEL_W-1:0]            rd_evt,
  input  logic                            rd_clear,
  output logic                            rd_valid,
  output logic [CNT_WIDTH-1:0]            rd_data,
  output logic                            rd_sat,
  output logic                            rd_err,
  output logic                            sat_any
);

  localparam int unsigned NUM_CNT = NUM_PORTS * NUM_EVENTS;

  logic [CNT_WIDTH-1:0] cnt_value [NUM_CNT];
  logic [NUM_CNT-1:0]   cnt_sat;
  logic [NUM_CNT-1:0]   cnt_sat_next_c;
  logic [NUM_CNT-1:0]   cnt_clr_c;
  logic                 in_range_c;
  logic [31:0]          rd_idx_c;
  logic [CNT_WIDTH-1:0] rd_value_c;
  logic                 rd_sat_c;

  // Counter array: flops so every counter can advance in the same cycle
  for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
    eth_stats_cnt #(
      .CNT_WIDTH (CNT_WIDTH),
      .SATURATE  (SATURATE)
    ) u_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .inc        (evt_pulse[g]),
      .clr        (cnt_clr_c[g]),
      .value      (cnt_value[g]),
      .sat        (cnt_sat[g]),
      .sat_next_c (cnt_sat_next_c[g])
    );
  end

  // Address decode, read mux of pre-update values, and clear steering
  always_comb begin
    in_range_c = (32'(rd_port) < NUM_PORTS) && (32'(rd_evt) < NUM_EVENTS);
    rd_idx_c   = 32'(rd_port) * NUM_EVENTS + 32'(rd_evt);
    rd_value_c = '0;
    rd_sat_c   = 1'b0;
    cnt_clr_c  = {NUM_CNT{clear_all}};
    for (int unsigned i = 0; i < NUM_CNT; i++) begin
      if (in_range_c && (rd_idx_c == i)) begin
        rd_value_c   = cnt_value[i];
        rd_sat_c     = cnt_sat[i];
        cnt_clr_c[i] = clear_all | (rd_req & rd_clear);
      end
    end
  end

  // Read response register; data/sat/err hold between responses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_sat   <= 1'b0;
      rd_err   <= 1'b0;
      sat_any  <= 1'b0;
    end else begin
      rd_valid <= rd_req;
      sat_any  <= |cnt_sat_next_c;
      if (rd_req) begin
        rd_data <= rd_value_c;
        rd_sat  <= rd_sat_c;
        rd_err  <= ~in_range_c;
      end
    end
  end

endmodule

// File: tb/tb_eth_mac_stats_counters.sv
// Directed bench for eth_mac_stats_counters: a saturating and a wrapping 8-bit instance.
module tb_eth_mac_stats_counters;
  import eth_stats_pkg::*;

  localparam int unsigned NP = 4;
  localparam int unsigned NE = 8;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NP*NE-1:0] evt_pulse;
  logic          clear_all;
  logic          rd_req;
  logic [3:0]    rd_port;
  logic [3:0]    rd_evt;
  logic          rd_clear;

  logic          rd_valid, rd_sat, rd_err, sat_any;
  logic [CW-1:0] rd_data;
  logic          w_rd_valid, w_rd_sat, w_rd_err, w_sat_any;
  logic [CW-1:0] w_rd_data;

  int checks   = 0;
  int failures = 0;

  eth_mac_stats_counters #(
    .NUM_PORTS(NP), .NUM_EVENTS(NE), .CNT_WIDTH(CW), .SATURATE(1'b1),
    .PORT_SEL_W(4), .EVT_SEL_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .evt_pulse(evt_pulse), .clear_all(clear_all),
    .rd_req(rd_req), .rd_port(rd_port), .rd_evt(rd_evt), .rd_clear(rd_clear),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_sat(rd_sat), .rd_err(rd_err),
    .sat_any(sat_any)
  );

  eth_mac_stats_counters #(
    .NUM_PORTS(NP), .NUM_EVENTS(NE), .CNT_WIDTH(CW), .SATURATE(1'b0),
    .PORT_SEL_W(4), .EVT_SEL_W(4)
  ) dut_wrap (
    .clk(clk), .rst_n(rst_n), .evt_pulse(evt_pulse), .clear_all(clear_all),
    .rd_req(rd_req), .rd_port(rd_port), .rd_evt(rd_evt), .rd_clear(rd_clear),
    .rd_valid(w_rd_valid), .rd_data(w_rd_data), .rd_sat(w_rd_sat), .rd_err(w_rd_err),
    .sat_any(w_sat_any)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_read(input int p, input int e, input bit clr);
    rd_req   = 1'b1;
    rd_port  = 4'(p);
    rd_evt   = 4'(e);
    rd_clear = clr;
    tick(1);
    rd_req   = 1'b0;
    rd_clear = 1'b0;
  endtask

  task automatic pulse_mask(input logic [NP*NE-1:0] mask, input int n);
    evt_pulse = mask;
    tick(n);
    evt_pulse = '0;
  endtask

  task automatic do_clear_all();
    clear_all = 1'b1;
    tick(1);
    clear_all = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #17;
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b expected 0", rd_valid); end
    checks++; if (rd_data !== 8'd0) begin failures++; $display("FAIL reset_data: got %0d expected 0", rd_data); end
    checks++; if (rd_sat !== 1'b0 || rd_err !== 1'b0) begin failures++; $display("FAIL reset_sat_err: got sat=%0b err=%0b expected 0 0", rd_sat, rd_err); end
    checks++; if (sat_any !== 1'b0) begin failures++; $display("FAIL reset_sat_any: got %0b expected 0", sat_any); end
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_count();
    pulse_mask(32'(1) << (2*NE + EVT_RX_BAD_FCS), 5);
    do_read(2, EVT_RX_BAD_FCS, 1'b0);
    checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL count_valid: got %0b expected 1", rd_valid); end
    checks++; if (rd_data !== 8'd5) begin failures++; $display("FAIL count_data: got %0d expected 5", rd_data); end
    checks++; if (rd_sat !== 1'b0 || rd_err !== 1'b0) begin failures++; $display("FAIL count_sat_err: got sat=%0b err=%0b expected 0 0", rd_sat, rd_err); end
    checks++; if (w_rd_data !== 8'd5) begin failures++; $display("FAIL count_wrap_data: got %0d expected 5", w_rd_data); end
    tick(1);
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL count_valid_drop: got %0b expected 0", rd_valid); end
    checks++; if (rd_data !== 8'd5) begin failures++; $display("FAIL count_data_hold: got %0d expected 5", rd_data); end
    for (int i = 0; i < int'(NP*NE); i++) begin
      if (i != 21) begin
        do_read(i / NE, i % NE, 1'b0);
        checks++; if (rd_data !== 8'd0) begin failures++; $display("FAIL count_other_%0d: got %0d expected 0", i, rd_data); end
      end
    end
  endtask

  task automatic test_clear_on_read();
    pulse_mask(32'(1) << 11, 7);
    evt_pulse = 32'(1) << 11;
    do_read(1, 3, 1'b1);
    evt_pulse = '0;
    checks++; if (rd_data !== 8'd7) begin failures++; $display("FAIL clr_read_first: got %0d expected 7", rd_data); end
    do_read(1, 3, 1'b0);
    checks++; if (rd_data !== 8'd1) begin failures++; $display("FAIL clr_read_second: got %0d expected 1", rd_data); end
    do_read(2, 5, 1'b0);
    checks++; if (rd_data !== 8'd5) begin failures++; $display("FAIL clr_read_neighbour: got %0d expected 5", rd_data); end
  endtask

  task automatic test_saturate();
    do_clear_all();
    pulse_mask(32'(1), 255);
    tick(1);
    checks++; if (sat_any !== 1'b0) begin failures++; $display("FAIL sat_any_early: got %0b expected 0", sat_any); end
    pulse_mask(32'(1), 45);
    checks++; if (sat_any !== 1'b1) begin failures++; $display("FAIL sat_any_set: got %0b expected 1", sat_any); end
    do_read(0, 0, 1'b0);
    checks++; if (rd_data !== 8'd255 || rd_sat !== 1'b1) begin failures++; $display("FAIL sat_read: got data=%0d sat=%0b expected 255 1", rd_data, rd_sat); end
    checks++; if (w_rd_data !== 8'd44 || w_rd_sat !== 1'b1) begin failures++; $display("FAIL wrap300_read: got data=%0d sat=%0b expected 44 1", w_rd_data, w_rd_sat); end
    do_clear_all();
    checks++; if (sat_any !== 1'b0) begin failures++; $display("FAIL sat_any_clear: got %0b expected 0", sat_any); end
    do_read(0, 0, 1'b0);
    checks++; if (rd_data !== 8'd0 || rd_sat !== 1'b0) begin failures++; $display("FAIL sat_after_clear: got data=%0d sat=%0b expected 0 0", rd_data, rd_sat); end
    do_read(2, 5, 1'b0);
    checks++; if (rd_data !== 8'd0) begin failures++; $display("FAIL clear_all_other: got %0d expected 0", rd_data); end
  endtask

  task automatic test_wrap();
    pulse_mask(32'(1), 257);
    do_read(0, 0, 1'b0);
    checks++; if (w_rd_data !== 8'd1 || w_rd_sat !== 1'b1) begin failures++; $display("FAIL wrap_read: got data=%0d sat=%0b expected 1 1", w_rd_data, w_rd_sat); end
    checks++; if (rd_data !== 8'd255 || rd_sat !== 1'b1) begin failures++; $display("FAIL wrap_sat_peer: got data=%0d sat=%0b expected 255 1", rd_data, rd_sat); end
    checks++; if (w_sat_any !== 1'b1) begin failures++; $display("FAIL wrap_sat_any: got %0b expected 1", w_sat_any); end
    do_clear_all();
  endtask

  task automatic test_out_of_range();
    pulse_mask((32'(1) << 0) | (32'(1) << 8) | (32'(1) << 17), 3);
    do_read(5, 0, 1'b1);
    checks++; if (rd_valid !== 1'b1 || rd_err !== 1'b1) begin failures++; $display("FAIL oor_port5: got valid=%0b err=%0b expected 1 1", rd_valid, rd_err); end
    checks++; if (rd_data !== 8'd0 || rd_sat !== 1'b0) begin failures++; $display("FAIL oor_port5_data: got data=%0d sat=%0b expected 0 0", rd_data, rd_sat); end
    do_read(4, 0, 1'b1);
    checks++; if (rd_err !== 1'b1 || rd_data !== 8'd0) begin failures++; $display("FAIL oor_port4: got err=%0b data=%0d expected 1 0", rd_err, rd_data); end
    do_read(1, 9, 1'b1);
    checks++; if (rd_err !== 1'b1 || rd_data !== 8'd0) begin failures++; $display("FAIL oor_evt9: got err=%0b data=%0d expected 1 0", rd_err, rd_data); end
    do_read(0, 0, 1'b0);
    checks++; if (rd_data !== 8'd3 || rd_err !== 1'b0) begin failures++; $display("FAIL oor_keep_0: got data=%0d err=%0b expected 3 0", rd_data, rd_err); end
    do_read(1, 0, 1'b0);
    checks++; if (rd_data !== 8'd3) begin failures++; $display("FAIL oor_keep_8: got %0d expected 3", rd_data); end
    do_read(2, 1, 1'b0);
    checks++; if (rd_data !== 8'd3) begin failures++; $display("FAIL oor_keep_17: got %0d expected 3", rd_data); end
    do_clear_all();
  endtask

  task automatic test_back_to_back();
    int exp;
    for (int k = 0; k < 20; k++) begin
      evt_pulse = (k < 10) ? '1 : '0;
      rd_req  = 1'b1;
      rd_port = 4'(k / NE);
      rd_evt  = 4'(k % NE);
      tick(1);
      exp = (k < 10) ? k : 10;
      checks++; if (rd_valid !== 1'b1 || rd_err !== 1'b0) begin failures++; $display("FAIL b2b_valid_%0d: got valid=%0b err=%0b expected 1 0", k, rd_valid, rd_err); end
      checks++; if (rd_data !== 8'(exp)) begin failures++; $display("FAIL b2b_data_%0d: got %0d expected %0d", k, rd_data, exp); end
    end
    evt_pulse = '0;
    rd_port   = 4'd2;
    rd_evt    = 4'd4;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (rd_valid !== 1'b0 || rd_data !== 8'd0) begin failures++; $display("FAIL b2b_reset_out: got valid=%0b data=%0d expected 0 0", rd_valid, rd_data); end
    checks++; if (rd_sat !== 1'b0 || rd_err !== 1'b0 || sat_any !== 1'b0) begin failures++; $display("FAIL b2b_reset_flags: got sat=%0b err=%0b any=%0b expected 0 0 0", rd_sat, rd_err, sat_any); end
    tick(1);
    rst_n  = 1'b1;
    rd_req = 1'b0;
    tick(1);
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL b2b_abandoned: got %0b expected 0", rd_valid); end
    do_read(3, 7, 1'b0);
    checks++; if (rd_data !== 8'd0) begin failures++; $display("FAIL b2b_post_reset_31: got %0d expected 0", rd_data); end
    do_read(0, 0, 1'b0);
    checks++; if (rd_data !== 8'd0) begin failures++; $display("FAIL b2b_post_reset_0: got %0d expected 0", rd_data); end
  endtask

  initial begin
    rst_n     = 1'b0;
    evt_pulse = '0;
    clear_all = 1'b0;
    rd_req    = 1'b0;
    rd_port   = '0;
    rd_evt    = '0;
    rd_clear  = 1'b0;
    test_reset();
    test_count();
    test_clear_on_read();
    test_saturate();
    test_wrap();
    test_out_of_range();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
